// File: rtl/sd_spi_byte_master_if.sv
// rtl/sd_spi_byte_master_if.sv - host-side byte and burst handshake bundle for sd_spi_byte_master
interface sd_spi_byte_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cs_assert;
    logic       fast;
    logic       burst_start;
    logic [9:0] burst_len;
    logic       burst_busy;

    modport master (
        output tx_data, tx_valid, cs_assert, fast, burst_start, burst_len,
        input  tx_ready, rx_data, rx_valid, burst_busy
    );

    modport slave (
        input  tx_data, tx_valid, cs_assert, fast, burst_start, burst_len,
        output tx_ready, rx_data, rx_valid, burst_busy
    );
endinterface

// File: rtl/sd_spi_byte_master.sv
// rtl/sd_spi_byte_master.sv - SPI mode-0 byte engine for the SD card pins; read burst enabled by SD_SPI_BURST_EN
module sd_spi_byte_master #(
    parameter int DIV_SLOW = 64,
    parameter int DIV_FAST = 2,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    sd_spi_byte_master_if.slave host,
    output logic                sd_cs,
    output logic                sd_clk,
    output logic                sd_mosi,
    input  logic                sd_miso
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [DIV_W-1:0] div_q, div_q_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [7:0]       rx_hold, rx_hold_nxt;
    logic             cs_q, cs_nxt;
    logic             clk_q, mosi_q;
    logic             half_done, byte_done, tx_ready_i, burst_busy_i, load;
    logic [7:0]       load_data;

`ifdef SD_SPI_BURST_EN
    logic             burst_q, burst_nxt, burst_begin, burst_more;
    logic [9:0]       burst_left, burst_left_nxt;
`else
    logic             unused_burst;
    assign unused_burst = ^{host.burst_start, host.burst_len};
`endif

    always_comb begin
        half_done    = (div_cnt == div_q - DIV_W'(1));
        byte_done    = (state == HIGH) && half_done && (bit_cnt == 3'd7);
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        div_q_nxt    = div_q;
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_hold_nxt  = rx_hold;
        cs_nxt       = cs_q;
        load         = 1'b0;
        load_data    = host.tx_data;

`ifdef SD_SPI_BURST_EN
        burst_nxt      = burst_q;
        burst_left_nxt = burst_left;
        burst_begin    = (state == IDLE) && !burst_q && host.burst_start && (host.burst_len != 10'd0);
        burst_more     = burst_q && byte_done && (burst_left != 10'd1);
        // busy drops in the cycle of the final byte's rx_valid so a new byte can follow at once
        burst_busy_i   = burst_q && !(byte_done && (burst_left == 10'd1));
        tx_ready_i     = ((state == IDLE) || byte_done) && !burst_busy_i && !burst_begin;
`else
        burst_busy_i   = 1'b0;
        tx_ready_i     = (state == IDLE) || byte_done;
`endif

        if (host.tx_valid && tx_ready_i) begin
            load = 1'b1;
        end

`ifdef SD_SPI_BURST_EN
        if (burst_begin || burst_more) begin
            load      = 1'b1;
            load_data = 8'hFF;
        end
        if (burst_begin) begin
            burst_nxt      = 1'b1;
            burst_left_nxt = host.burst_len;
        end else if (burst_q && byte_done) begin
            burst_left_nxt = burst_left - 10'd1;
            if (burst_left == 10'd1) begin
                burst_nxt = 1'b0;
            end
        end
`endif

        unique case (state)
            IDLE: begin
                cs_nxt = ~host.cs_assert;
            end
            LOW: begin
                if (half_done) begin
                    // MISO is captured on the SCK rising edge, after a full low half-period of setup
                    state_nxt    = HIGH;
                    div_cnt_nxt  = '0;
                    rx_shift_nxt = {rx_shift[6:0], sd_miso};
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            HIGH: begin
                if (half_done) begin
                    div_cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt   = IDLE;
                        rx_hold_nxt = rx_shift;
                    end else begin
                        state_nxt    = LOW;
                        bit_cnt_nxt  = bit_cnt + 3'd1;
                        tx_shift_nxt = {tx_shift[6:0], 1'b1};
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // a load in the completing HIGH cycle chains straight into the next byte's low phase
        if (load) begin
            state_nxt    = LOW;
            div_cnt_nxt  = '0;
            bit_cnt_nxt  = '0;
            tx_shift_nxt = load_data;
            div_q_nxt    = host.fast ? DIV_W'(DIV_FAST) : DIV_W'(DIV_SLOW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            div_q    <= DIV_W'(DIV_SLOW);
            bit_cnt  <= '0;
            tx_shift <= 8'hFF;
            rx_shift <= 8'h00;
            rx_hold  <= 8'h00;
            cs_q     <= 1'b1;
            clk_q    <= 1'b0;
            mosi_q   <= 1'b1;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            div_q    <= div_q_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            rx_hold  <= rx_hold_nxt;
            cs_q     <= cs_nxt;
            clk_q    <= (state_nxt == HIGH);
            mosi_q   <= (state_nxt == IDLE) ? 1'b1 : tx_shift_nxt[7];
        end
    end

`ifdef SD_SPI_BURST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q    <= 1'b0;
            burst_left <= '0;
        end else begin
            burst_q    <= burst_nxt;
            burst_left <= burst_left_nxt;
        end
    end
`endif

    assign sd_cs           = cs_q;
    assign sd_clk          = clk_q;
    assign sd_mosi         = mosi_q;
    assign host.tx_ready   = tx_ready_i;
    assign host.rx_valid   = byte_done;
    assign host.rx_data    = byte_done ? rx_shift : rx_hold;
    assign host.burst_busy = burst_busy_i;
endmodule

// File: tb/tb_sd_spi_byte_master.sv
// tb/tb_sd_spi_byte_master.sv - scoreboard bench for sd_spi_byte_master with an SD card shift model
`timescale 1ns/1ps
module tb_sd_spi_byte_master;
    localparam int DIV_SLOW = 4;
    localparam int DIV_FAST = 1;

    typedef struct {
        logic [7:0] data;
        int         at;
    } rx_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sd_cs, sd_clk, sd_mosi, sd_miso;

    sd_spi_byte_master_if host();

    sd_spi_byte_master #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .host(host),
        .sd_cs(sd_cs), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         gap_base    = -1;
    int         sck_rises   = 0;
    int         mosi_bits   = 0;
    int         card_bit    = 0;
    logic [7:0] mosi_acc    = 8'h00;
    logic [7:0] card_cur    = 8'hFF;
    rx_exp_t    rx_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] card_q[$];
    rx_exp_t    rx_e;
    logic [7:0] mosi_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // card: drives MSB first, advances on SCK falling edges
    assign sd_miso = card_cur[3'd7 - card_bit[2:0]];
    always @(negedge sd_clk) begin
        if (card_bit == 7) begin
            card_bit = 0;
            card_cur = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
        end else begin
            card_bit++;
        end
    end

    always @(posedge sd_clk) begin
        sck_rises++;
        mosi_acc = {mosi_acc[6:0], sd_mosi};
        mosi_bits++;
        if (mosi_bits == 8) begin
            mosi_bits = 0;
            if (mosi_q.size() == 0) begin
                check("mosi_pending", 32'(mosi_q.size()), 32'd1);
            end else begin
                mosi_e = mosi_q.pop_front();
                check("mosi_byte", 32'(mosi_acc), 32'(mosi_e));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && host.rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
                check("rx_pending", 32'(rx_q.size()), 32'd1);
            end else begin
                rx_e = rx_q.pop_front();
                check("rx_data", 32'(host.rx_data), 32'(rx_e.data));
                check("rx_cycle", 32'(cyc), 32'(rx_e.at));
            end
        end
    end

    always @(negedge clk) begin
        if (gap_base >= 0 && cyc > gap_base && cyc <= gap_base + 32)
            check("sck_gapless", 32'(sd_clk), 32'(((cyc - gap_base) % 2) == 0));
    end

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 5000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_ready(output int acc);
        int g = 0;
        acc = -1;
        while (acc < 0 && g < 500) begin
            @(negedge clk);
            if (host.tx_ready === 1'b1) acc = cyc;
            g++;
        end
        if (acc < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
            acc = cyc;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] reply, input logic f,
                        input int div, input logic expect_done, output int acc);
        host.tx_data  = d;
        host.fast     = f;
        host.tx_valid = 1'b1;
        wait_ready(acc);
        if (expect_done) begin
            mosi_q.push_back(d);
            rx_q.push_back('{reply, acc + 16 * div});
        end
        @(posedge clk);
        #1 host.tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (rx_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() != 0) begin
            check("drain_timeout", 32'(rx_q.size()), 32'd0);
            rx_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2, c, sck0;
        host.tx_data     = 8'h00;
        host.tx_valid    = 1'b0;
        host.cs_assert   = 1'b0;
        host.fast        = 1'b0;
        host.burst_start = 1'b0;
        host.burst_len   = 10'd0;

        repeat (3) @(negedge clk);
        check("rst_sd_cs", 32'(sd_cs), 32'd1);
        check("rst_sd_clk", 32'(sd_clk), 32'd0);
        check("rst_sd_mosi", 32'(sd_mosi), 32'd1);
        check("rst_tx_ready", 32'(host.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(host.rx_valid), 32'd0);
        check("rst_rx_data", 32'(host.rx_data), 32'h00);
        check("rst_burst_busy", 32'(host.burst_busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        card_bit  = 0;
        mosi_bits = 0;

        // slow byte: 0xA5 out, 0x3C back, 16*4 cycles
        host.cs_assert = 1'b1;
        @(posedge clk);
        #1 card_cur = 8'h3C;
        send(8'hA5, 8'h3C, 1'b0, DIV_SLOW, 1'b1, acc);
        wait_cyc(acc + 30);
        check("cs_low_during_xfer", 32'(sd_cs), 32'd0);
        drain(200);

        // fast back-to-back with tx_valid held
        card_cur = 8'hC3;
        card_q.push_back(8'h5A);
        mosi_q.push_back(8'h40);
        mosi_q.push_back(8'h95);
        host.fast     = 1'b1;
        host.tx_data  = 8'h40;
        host.tx_valid = 1'b1;
        wait_ready(acc1);
        gap_base = acc1;
        rx_q.push_back('{8'hC3, acc1 + 16});
        @(posedge clk);
        #1 host.tx_data = 8'h95;
        wait_ready(acc2);
        check("b2b_accept_gap", 32'(acc2 - acc1), 32'd16);
        rx_q.push_back('{8'h5A, acc2 + 16});
        @(posedge clk);
        #1 host.tx_valid = 1'b0;
        drain(200);
        gap_base = -1;

        // cs_assert dropped during bit 3 stays frozen until IDLE
        card_cur = 8'h81;
        send(8'h5E, 8'h81, 1'b0, DIV_SLOW, 1'b1, acc);
        wait_cyc(acc + 26);
        host.cs_assert = 1'b0;
        wait_cyc(acc + 40);
        check("cs_frozen_mid", 32'(sd_cs), 32'd0);
        wait_cyc(acc + 64);
        check("cs_frozen_done", 32'(sd_cs), 32'd0);
        wait_cyc(acc + 65);
        check("cs_frozen_idle", 32'(sd_cs), 32'd0);
        wait_cyc(acc + 66);
        check("cs_release", 32'(sd_cs), 32'd1);
        host.cs_assert = 1'b1;
        drain(50);

        // reset after 3 bits aborts the byte
        card_cur = 8'h77;
        send(8'hC6, 8'h77, 1'b0, DIV_SLOW, 1'b0, acc);
        wait_cyc(acc + 26);
        reset = 1'b1;
        @(negedge clk);
        check("abort_sd_cs", 32'(sd_cs), 32'd1);
        check("abort_sd_clk", 32'(sd_clk), 32'd0);
        check("abort_sd_mosi", 32'(sd_mosi), 32'd1);
        check("abort_tx_ready", 32'(host.tx_ready), 32'd1);
        check("abort_rx_valid", 32'(host.rx_valid), 32'd0);
        check("abort_rx_data", 32'(host.rx_data), 32'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        card_bit  = 0;
        mosi_bits = 0;
        card_cur  = 8'h6B;
        send(8'h00, 8'h6B, 1'b0, DIV_SLOW, 1'b1, acc);
        drain(200);

`ifdef SD_SPI_BURST_EN
        host.fast = 1'b1;
        card_cur  = 8'hFE;
        card_q.push_back(8'h12);
        card_q.push_back(8'h34);
        repeat (3) mosi_q.push_back(8'hFF);
        host.burst_len   = 10'd3;
        host.burst_start = 1'b1;
        @(negedge clk);
        c = cyc;
        rx_q.push_back('{8'hFE, c + 16});
        rx_q.push_back('{8'h12, c + 32});
        rx_q.push_back('{8'h34, c + 48});
        @(posedge clk);
        #1 host.burst_start = 1'b0;
        host.tx_data  = 8'h00;
        host.tx_valid = 1'b1;
        wait_cyc(c + 5);
        check("burst_busy_high", 32'(host.burst_busy), 32'd1);
        check("burst_tx_ready_low", 32'(host.tx_ready), 32'd0);
        wait_cyc(c + 40);
        host.tx_valid = 1'b0;
        wait_cyc(c + 47);
        check("burst_busy_before_last", 32'(host.burst_busy), 32'd1);
        wait_cyc(c + 48);
        check("burst_busy_last", 32'(host.burst_busy), 32'd0);
        drain(100);

        host.burst_len   = 10'd0;
        host.burst_start = 1'b1;
        @(negedge clk);
        check("burst_zero_ready", 32'(host.tx_ready), 32'd1);
        @(posedge clk);
        #1 host.burst_start = 1'b0;
        @(negedge clk);
        check("burst_zero_busy", 32'(host.burst_busy), 32'd0);
        check("burst_zero_sck", 32'(sd_clk), 32'd0);
`else
        host.fast        = 1'b1;
        sck0             = sck_rises;
        host.burst_len   = 10'd3;
        host.burst_start = 1'b1;
        @(negedge clk);
        check("noburst_busy", 32'(host.burst_busy), 32'd0);
        @(posedge clk);
        #1 host.burst_start = 1'b0;
        repeat (60) @(negedge clk);
        check("noburst_busy_later", 32'(host.burst_busy), 32'd0);
        check("noburst_sck", 32'(sck_rises - sck0), 32'd0);
`endif

        drain(100);
        check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
        check("mosi_queue_empty", 32'(mosi_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
